// File: rtl/syn_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// Optional SYN_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags and an occupancy count output.
module syn_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
`ifdef SYN_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam int DEPTH_I = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(DEPTH_I);

  logic [DATA_WIDTH-1:0] mem [DEPTH_I];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt, cnt_next;
  logic                  rd_acc, wr_acc;

  // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
  always_comb begin
    rd_acc   = rd_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    cnt_next = cnt;
    if (wr_acc && !rd_acc)
      cnt_next = cnt + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_next = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      data_out <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      cnt   <= cnt_next;
      empty <= (cnt_next == '0);
      full  <= (cnt_next == DEPTH);
    end
  end

`ifdef SYN_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_acc)
        overflow <= 1'b1;
      if (rd_en && empty)
        underflow <= 1'b1;
    end
  end

  assign count = cnt;
`endif

endmodule

// File: tb/tb_syn_fifo.sv
// Self-checking bench for syn_fifo: directed scenarios plus random traffic against a queue model.
module tb_syn_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       rd_en, wr_en;
  logic [3:0] data_out;
  logic       empty, full;
`ifdef SYN_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
  logic [3:0] count;
`endif

  syn_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
`ifdef SYN_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow),
    .count    (count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q[$];
  logic [3:0] m_dout;
  logic       m_ovf, m_unf;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, int'(data_out), int'(m_dout));
    check({tag, ".empty"}, int'(empty), int'(q.size() == 0));
    check({tag, ".full"}, int'(full), int'(q.size() == 8));
`ifdef SYN_FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    check({tag, ".underflow"}, int'(underflow), int'(m_unf));
    check({tag, ".count"}, int'(count), q.size());
`endif
  endtask

  // One clock of traffic: drive on the falling edge, apply FIFO rules to the model, compare after the rising edge.
  task automatic step(input logic w, input logic r, input logic [3:0] d, input string tag);
    logic do_rd, do_wr;
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    do_rd = r && (q.size() > 0);
    do_wr = w && (q.size() < 8 || do_rd);
    if (w && q.size() == 8 && !r) m_ovf = 1'b1;
    if (r && q.size() == 0) m_unf = 1'b1;
    if (do_rd) m_dout = q.pop_front();
    if (do_wr) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".empty"}, int'(empty), 1);
    check({tag, ".full"}, int'(full), 0);
    check({tag, ".data_out"}, int'(data_out), 0);
    #9 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();
    #12 rst = 1'b0;
    #1 check_all("por");

    pulse_reset("rst1");

    step(1, 0, 4'h4, "w4");
    step(1, 0, 4'hD, "wD");
    step(0, 1, 4'h0, "rd1");
    check("rd1.const", int'(data_out), 4);
    step(0, 1, 4'h0, "rd2");
    check("rd2.const", int'(data_out), 'hD);
    check("rd2.empty", int'(empty), 1);
    step(0, 1, 4'h0, "rd_empty");
    check("rd_empty.hold", int'(data_out), 'hD);
`ifdef SYN_FIFO_ERR_FLAGS_EN
    check("rd_empty.underflow", int'(underflow), 1);
`endif
    // Pointers untouched by the ignored read: next write/read pair round-trips.
    step(1, 0, 4'h6, "post_empty_w");
    step(0, 1, 4'h0, "post_empty_r");
    check("post_empty_r.const", int'(data_out), 6);

    pulse_reset("rst2");
    for (int unsigned i = 0; i < 8; i++) step(1, 0, 4'(i), "fill");
    check("fill.full", int'(full), 1);
    step(1, 0, 4'hF, "ovf_write");
    check("ovf_write.full", int'(full), 1);
`ifdef SYN_FIFO_ERR_FLAGS_EN
    check("ovf_write.overflow", int'(overflow), 1);
`endif
    for (int unsigned i = 0; i < 8; i++) begin
      step(0, 1, 4'h0, "drain");
      check("drain.const", int'(data_out), int'(i));
    end
    check("drain.empty", int'(empty), 1);

    pulse_reset("rst3");
    for (int unsigned i = 0; i < 8; i++) step(1, 0, 4'(i), "fill2");
    step(1, 1, 4'hA, "full_rw");
    check("full_rw.const", int'(data_out), 0);
    check("full_rw.full", int'(full), 1);
    for (int unsigned i = 1; i < 9; i++) begin
      step(0, 1, 4'h0, "drain2");
      check("drain2.const", int'(data_out), (i == 8) ? 'hA : int'(i));
    end

    pulse_reset("rst4");
    for (int unsigned i = 0; i < 12; i++) begin
      step(1, 0, 4'(i), "wrap_w");
      step(0, 1, 4'h0, "wrap_r");
      check("wrap_r.const", int'(data_out), int'(i));
    end
    step(1, 0, 4'h3, "mid_w");
    step(1, 0, 4'h5, "mid_w");
    pulse_reset("rst_mid");

    // Random traffic in phases biased toward filling, draining and balance.
    for (int unsigned ph = 0; ph < 6; ph++) begin
      int unsigned pw;
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      for (int unsigned k = 0; k < 60; k++) begin
        logic w, r;
        w = ($urandom_range(99) < pw);
        r = ($urandom_range(99) < 100 - pw);
        step(w, r, 4'($urandom), "rand");
      end
    end

    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/syn_fifo.md
Name: syn_fifo

Overview:
Single-clock synchronous FIFO with registered read data and full/empty status flags. It buffers narrow data words between a producer and a consumer in the same clock domain inside the shared-buffer subsystem. Both ports use simple enable strobes with no backpressure handshake beyond the full and empty flags.

Parameters:
DATA_WIDTH, 4, width of each stored word in bits.
ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8 entries.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
data_in  input  DATA_WIDTH  write data, sampled on the rising edge when a write is accepted.
rd_en  input  1  read request strobe.
wr_en  input  1  write request strobe.
data_out  output  DATA_WIDTH  registered read data.
empty  output  1  high when the FIFO holds 0 entries.
full  output  1  high when the FIFO holds 2**ADDR_WIDTH entries.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Storage is a 2**ADDR_WIDTH x DATA_WIDTH register array.
- Pointers and count:
  - Write pointer and read pointer are ADDR_WIDTH bits and wrap naturally modulo depth.
  - Occupancy count is ADDR_WIDTH+1 bits.
- Reset, asserted at any time including mid-operation: pointers=0, count=0, data_out=0, empty=1, full=0. Array contents need not be cleared.
- Write accepted when wr_en=1 and (full=0, or rd_en=1 with a read also accepted):
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments.
- Read accepted when rd_en=1 and empty=0:
  - data_out <= mem[rd_ptr] at the same edge. Data is visible 1 cycle after the strobe edge.
  - rd_ptr increments.
- data_out holds its last value whenever no read is accepted, including reads attempted on empty.
- Write while full with no read: ignored. Data, pointers and flags are unchanged.
- Read while empty: ignored. data_out, pointers and flags are unchanged.
- Simultaneous rd_en and wr_en:
  - Non-empty and not full: both happen, count unchanged.
  - Full: both happen; the read takes the oldest word and the write fills the freed slot. full stays 1.
  - Empty: only the write happens; the new word is not bypassed to data_out. empty deasserts next cycle.
- Count update: +1 on write-only, -1 on read-only, unchanged otherwise.
- empty and full are registered, derived from the next count, and valid the cycle after the causing edge.
- Data wider than DATA_WIDTH is truncated by the driver; the FIFO stores only DATA_WIDTH bits.

Optional Feature:
Macro SYN_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds output overflow (1 bit), a sticky flag set when a write is rejected because the FIFO is full.
  - Adds output underflow (1 bit), a sticky flag set when a read is attempted while empty.
  - Both flags clear only on rst.
  - Adds output count (ADDR_WIDTH+1 bits) exposing current occupancy.
- Not defined: these ports and their logic are absent; core behaviour is identical.

Test Plan:
- Reset: pulse rst high for 10 ns asynchronously between edges -> immediately empty=1, full=0, data_out=0.
- Write 4'h4 then 4'hD on two consecutive edges, then read -> after the first read edge data_out=4; after the second, data_out=4'hD and empty=1.
- Read on empty after draining -> data_out stays 4'hD, empty=1, pointers unchanged; underflow=1 when SYN_FIFO_ERR_FLAGS_EN is defined.
- Write 8 words 0..7 -> full=1 after the 8th edge. A 9th write of 4'hF is ignored; reading 8 times returns 0..7 in order, then empty=1.
- Full, simultaneous rd_en and wr_en with data 4'hA -> data_out=0 (oldest word), full stays 1; draining returns 1..7 then A.
- Wrap-around: 12 interleaved write/read pairs with values 0..11 -> every read returns the matching value, exercising pointer wrap. Asserting rst mid-stream returns empty=1, data_out=0.
